// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the
//            PC, issues valid/ready requests to instruction memory and loads
//            the IF/ID pipeline register. Consumes the ID-stage branch/jump
//            resolution (redirect + squash), honours load-use stalls and
//            absorbs multi-cycle memory latency.
// Ports    : clk, rst_n               clock, async active-low reset
//            Hazard                   load-use stall (holds PC and IF/ID)
//            isBranch/branch_target   taken branch resolved in ID
//            Jump/jump_target         jump resolved in ID (wins over branch)
//            IF_Flush                 squash the IF/ID slot
//            imem_req/imem_addr       request to instruction memory
//            imem_ready/imem_rdata    memory accept + same-cycle data
//            if_id_valid/pc4/instr    IF/ID pipeline register
//            fetch_busy               request outstanding, not yet accepted
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Hazard,
    input  logic        isBranch,
    input  logic [31:0] branch_target,
    input  logic        Jump,
    input  logic [31:0] jump_target,
    input  logic        IF_Flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] c_pc_reset = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pending_pc;
    logic [31:0] w_pending_nxt;
    logic        r_if_id_valid;
    logic        w_if_id_valid_nxt;
    logic [31:0] r_if_id_pc4;
    logic [31:0] w_if_id_pc4_nxt;
    logic [31:0] r_if_id_instr;
    logic [31:0] w_if_id_instr_nxt;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;

    assign w_redirect   = Jump || isBranch;
    assign w_target_raw = Jump ? jump_target : branch_target;
    assign w_target     = {w_target_raw[31:2], 2'b00};
    assign w_pc_plus4   = r_pc + 32'd4;

    // Request is decoded from registered state so that an async reset drops
    // it immediately; the address is the PC, which only moves on a handshake.
    assign imem_req    = (r_state != S_IDLE);
    assign imem_addr   = r_pc;
    assign fetch_busy  = imem_req && !imem_ready;
    assign if_id_valid = r_if_id_valid;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_instr = r_if_id_instr;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pending_nxt     = r_pending_pc;
        w_if_id_valid_nxt = r_if_id_valid;
        w_if_id_pc4_nxt   = r_if_id_pc4;
        w_if_id_instr_nxt = r_if_id_instr;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    if (w_redirect) begin
                        w_pc_nxt          = w_target;
                        w_if_id_valid_nxt = 1'b0;
                        w_if_id_pc4_nxt   = 32'd0;
                        w_if_id_instr_nxt = 32'd0;
                    end else if (!Hazard) begin
                        w_pc_nxt          = w_pc_plus4;
                        w_if_id_valid_nxt = 1'b1;
                        w_if_id_pc4_nxt   = w_pc_plus4;
                        w_if_id_instr_nxt = imem_rdata;
                    end
                    // Hazard alone: word dropped, same PC refetched next cycle.
                end else begin
                    if (w_redirect) begin
                        // Address must stay stable until accepted, so park
                        // the target and drain the outstanding request.
                        w_pending_nxt     = w_target;
                        w_state_nxt       = S_DRAIN;
                        w_if_id_valid_nxt = 1'b0;
                        w_if_id_pc4_nxt   = 32'd0;
                        w_if_id_instr_nxt = 32'd0;
                    end else if (!Hazard) begin
                        w_if_id_valid_nxt = 1'b0;
                        w_if_id_pc4_nxt   = 32'd0;
                        w_if_id_instr_nxt = 32'd0;
                    end
                end
            end
            S_DRAIN: begin
                if (w_redirect) begin
                    w_pending_nxt = w_target;
                end
                if (w_redirect || !Hazard) begin
                    w_if_id_valid_nxt = 1'b0;
                    w_if_id_pc4_nxt   = 32'd0;
                    w_if_id_instr_nxt = 32'd0;
                end
                if (imem_ready) begin
                    // Returned word belongs to the squashed path; discard it.
                    w_pc_nxt    = w_redirect ? w_target : r_pending_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (IF_Flush) begin
            w_if_id_valid_nxt = 1'b0;
            w_if_id_pc4_nxt   = 32'd0;
            w_if_id_instr_nxt = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= c_pc_reset;
            r_pending_pc  <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc4   <= 32'd0;
            r_if_id_instr <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pending_pc  <= w_pending_nxt;
            r_if_id_valid <= w_if_id_valid_nxt;
            r_if_id_pc4   <= w_if_id_pc4_nxt;
            r_if_id_instr <= w_if_id_instr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. Two instances share
//            stimulus: one reset to 0x100, one reset to 0xFFFF_FFF8 to cover
//            PC wrap. Memory model returns addr ^ 0xA5A5 in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Hazard = 1'b0;
    logic        isBranch = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        Jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        IF_Flush = 1'b0;
    logic        imem_ready = 1'b1;

    logic        req_a, valid_a, busy_a;
    logic [31:0] addr_a, rdata_a, pc4_a, instr_a;
    logic        req_b, valid_b, busy_b;
    logic [31:0] addr_b, rdata_b, pc4_b, instr_b;

    assign rdata_a = addr_a ^ 32'h0000_A5A5;
    assign rdata_b = addr_b ^ 32'h0000_A5A5;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut_a (
        .clk(clk), .rst_n(rst_n), .Hazard(Hazard),
        .isBranch(isBranch), .branch_target(branch_target),
        .Jump(Jump), .jump_target(jump_target), .IF_Flush(IF_Flush),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready),
        .imem_rdata(rdata_a), .if_id_valid(valid_a), .if_id_pc4(pc4_a),
        .if_id_instr(instr_a), .fetch_busy(busy_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst_n(rst_n), .Hazard(Hazard),
        .isBranch(isBranch), .branch_target(branch_target),
        .Jump(Jump), .jump_target(jump_target), .IF_Flush(IF_Flush),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ready(imem_ready),
        .imem_rdata(rdata_b), .if_id_valid(valid_b), .if_id_pc4(pc4_b),
        .if_id_instr(instr_b), .fetch_busy(busy_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected IF/ID content for an instruction fetched from addr.
    task automatic push_fetch(input logic [31:0] addr);
        exp_t e;
        e.pc4   = addr + 32'd4;
        e.instr = addr ^ 32'h0000_A5A5;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic v, input logic [31:0] p4,
                            input logic [31:0] ins);
        exp_t e;
        total++;
        assert (sb_q.size() > 0) else begin
            bad++;
            $error("FAIL %s: observed=empty-queue expected=entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, {31'd0, v}, 32'd1);
            chk({tag, "_pc4"}, p4, e.pc4);
            chk({tag, "_instr"}, ins, e.instr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_req", {31'd0, req_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_pc4", pc4_a, 32'd0);
        chk("rst_instr", instr_a, 32'd0);
        rst_n = 1'b1;
        tick();                                   // IDLE -> FETCH
        chk("first_req", {31'd0, req_a}, 32'd1);
        chk("first_addr", addr_a, 32'h100);

        // ---------------- zero-wait streaming ----------------
        push_fetch(32'h100);
        tick();
        sb_check("stream0", valid_a, pc4_a, instr_a);
        chk("addr_104", addr_a, 32'h104);
        push_fetch(32'h104);
        tick();
        sb_check("stream1", valid_a, pc4_a, instr_a);
        chk("addr_108", addr_a, 32'h108);

        // ---------------- hazard for two cycles ----------------
        Hazard = 1'b1;
        tick();
        chk("haz1_addr", addr_a, 32'h108);
        chk("haz1_pc4", pc4_a, 32'h108);
        tick();
        chk("haz2_addr", addr_a, 32'h108);
        chk("haz2_pc4", pc4_a, 32'h108);
        Hazard = 1'b0;
        push_fetch(32'h108);
        tick();
        sb_check("resume", valid_a, pc4_a, instr_a);
        chk("addr_10c", addr_a, 32'h10C);

        // ---------------- branch, then jump+branch together ----------------
        isBranch = 1'b1; branch_target = 32'h200;
        tick();
        chk("br_valid", {31'd0, valid_a}, 32'd0);
        chk("br_instr", instr_a, 32'd0);
        chk("br_addr", addr_a, 32'h200);
        Jump = 1'b1; jump_target = 32'h300; branch_target = 32'h400;
        tick();
        chk("jb_valid", {31'd0, valid_a}, 32'd0);
        chk("jb_addr", addr_a, 32'h300);
        Jump = 1'b0; isBranch = 1'b0;
        push_fetch(32'h300);
        tick();
        sb_check("after_jump", valid_a, pc4_a, instr_a);

        // ---------------- waited memory with redirects during drain --------
        Jump = 1'b1; jump_target = 32'h120;
        tick();
        chk("to_120", addr_a, 32'h120);
        Jump = 1'b0;
        imem_ready = 1'b0; isBranch = 1'b1; branch_target = 32'h500;
        #1;
        chk("w1_busy", {31'd0, busy_a}, 32'd1);
        chk("w1_addr", addr_a, 32'h120);
        tick();
        isBranch = 1'b0; Jump = 1'b1; jump_target = 32'h600;
        #1;
        chk("w2_busy", {31'd0, busy_a}, 32'd1);
        chk("w2_addr", addr_a, 32'h120);
        tick();
        Jump = 1'b0;
        #1;
        chk("w3_busy", {31'd0, busy_a}, 32'd1);
        chk("w3_addr", addr_a, 32'h120);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("w4_busy", {31'd0, busy_a}, 32'd0);
        chk("w4_addr", addr_a, 32'h120);
        tick();
        chk("drain_discard", {31'd0, valid_a}, 32'd0);
        chk("drain_addr", addr_a, 32'h600);
        push_fetch(32'h600);
        tick();
        sb_check("after_drain", valid_a, pc4_a, instr_a);

        // ---------------- IF_Flush overrides Hazard ----------------
        Hazard = 1'b1; IF_Flush = 1'b1;
        tick();
        chk("flush_valid", {31'd0, valid_a}, 32'd0);
        chk("flush_pc4", pc4_a, 32'd0);
        chk("flush_addr", addr_a, 32'h604);
        Hazard = 1'b0; IF_Flush = 1'b0;
        push_fetch(32'h604);
        tick();
        sb_check("pre_reset", valid_a, pc4_a, instr_a);

        // ---------------- reset mid-transaction ----------------
        imem_ready = 1'b0; Hazard = 1'b1;
        tick();
        chk("stall_hold", {31'd0, valid_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, req_a}, 32'd0);
        chk("async_busy", {31'd0, busy_a}, 32'd0);
        chk("async_valid", {31'd0, valid_a}, 32'd0);
        chk("async_pc4", pc4_a, 32'd0);
        tick();
        Hazard = 1'b0; imem_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("restart_addr", addr_a, 32'h100);
        chk("restart_req", {31'd0, req_a}, 32'd1);

        // ---------------- PC wrap on the second instance ----------------
        chk("wrap_addr0", addr_b, 32'hFFFF_FFF8);
        push_fetch(32'hFFFF_FFF8);
        tick();
        sb_check("wrap0", valid_b, pc4_b, instr_b);
        chk("wrap_addr1", addr_b, 32'hFFFF_FFFC);
        push_fetch(32'hFFFF_FFFC);
        tick();
        sb_check("wrap1", valid_b, pc4_b, instr_b);
        chk("wrap_addr2", addr_b, 32'h0000_0000);

        // ---------------- misaligned target is word-aligned ----------------
        isBranch = 1'b1; branch_target = 32'h203;
        tick();
        isBranch = 1'b0;
        chk("align_b", addr_b, 32'h200);
        chk("align_a", addr_a, 32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC and issues requests to instruction memory over a valid/ready handshake, then loads the IF/ID pipeline register. It is the direct consumer of the ID-stage branch/jump resolution: `isBranch`, `Jump` and `IF_Flush` redirect the PC and squash the fetched slot, and `Hazard` freezes the stage. Multi-cycle memory latency is absorbed here, and `fetch_busy` is exported to the rest of the pipeline.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `Hazard`  in  1  load-use stall; holds the PC and IF/ID.
- `isBranch`  in  1  taken beq/bne resolved in ID.
- `branch_target`  in  32  branch target address.
- `Jump`  in  1  jump resolved in ID.
- `jump_target`  in  32  jump target address.
- `IF_Flush`  in  1  squashes the IF/ID slot.
- `imem_req`  out  1  instruction memory request valid.
- `imem_addr`  out  32  request address, equal to the current PC.
- `imem_ready`  in  1  memory accepts the request and returns data in the same cycle.
- `imem_rdata`  in  32  instruction word; valid when `imem_req && imem_ready`.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc4`  out  32  PC+4 of the instruction in IF/ID.
- `if_id_instr`  out  32  instruction in IF/ID; 0 (nop) when invalid.
- `fetch_busy`  out  1  `imem_req && !imem_ready`.

## Operation
- **States:** IDLE, FETCH, DRAIN.
- **Reset values (asynchronous):**
  - state = IDLE; pc = RESET_PC; pending_pc = 0.
  - `if_id_valid` = 0, `if_id_pc4` = 0, `if_id_instr` = 0.
  - `imem_req` = 0, `fetch_busy` = 0.
- **IDLE:** `imem_req` = 0. On the first clock edge after `rst_n` deasserts, go to FETCH.
- **FETCH and DRAIN:** `imem_req` = 1 and `imem_addr` = pc. Once asserted, `imem_addr` must not change until `imem_ready` is seen.
- **Redirect:**
  - Redirect = `Jump || isBranch`. Target = `jump_target` if `Jump`, else `branch_target`.
  - Jump wins if both are asserted. Target bits [1:0] are forced to 0.
  - Redirect has priority over `Hazard`.
- **FETCH with handshake (`imem_ready` = 1):**
  - Redirect: pc <= target; IF/ID <= bubble; the fetched word is discarded.
  - Else `Hazard`: pc and IF/ID hold; the word is discarded and pc is refetched next cycle.
  - Else: pc <= pc+4; IF/ID <= {valid = 1, pc4 = pc+4, instr = `imem_rdata`}.
- **FETCH without handshake (`imem_ready` = 0):**
  - Redirect: pending_pc <= target; IF/ID <= bubble; go to DRAIN.
  - Else `Hazard`: IF/ID holds.
  - Else: IF/ID <= bubble.
- **DRAIN:**
  - `imem_req` stays asserted with the old address.
  - Every cycle IF/ID <= bubble, except that `Hazard` without a redirect holds IF/ID.
  - A new redirect overwrites pending_pc; the latest redirect wins.
  - On `imem_ready`: discard the data. pc <= the new target if a redirect is asserted this cycle, else pending_pc. Return to FETCH.
- **IF_Flush:** forces an IF/ID bubble in any state, even without a redirect. `IF_Flush` overrides `Hazard`.
- **Bubble:** valid = 0, pc4 = 0, instr = 0.
- **PC arithmetic:** pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). pc[1:0] is always 0.

## Timing
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle. An instruction presented at edge N appears in IF/ID after edge N.
- Redirect penalty:
  - Zero-wait memory: 1 bubble; the target is requested in the cycle after the redirect.
  - Waited memory: the outstanding request completes first, then the target is requested.
- First request: the first cycle after the IDLE->FETCH edge, so 1 cycle after reset release.
- Reset mid-transaction: the outstanding request is abandoned. `imem_req` drops immediately (asynchronously) and the stage restarts from RESET_PC.
- `fetch_busy` is combinational from state and `imem_ready`. All other outputs are registered except `imem_req` and `imem_addr`, which are decoded from registered state and pc.

## Test plan
- Reset, RESET_PC = 0x100, `imem_ready` = 1, memory returns addr^0xA5A5: addresses go 0x100, 0x104, 0x108. `if_id_pc4` = 0x104, 0x108; `if_id_valid` = 1 from the second post-reset edge.
- `Hazard` high for 2 cycles at pc = 0x108: `imem_addr` stays 0x108 and IF/ID holds for 2 cycles; fetch resumes with 0x108.
- `isBranch` with target 0x200 at pc = 0x10C: one bubble (valid 0, instr 0), next `imem_addr` = 0x200. Then `Jump` (0x300) and `isBranch` (0x400) together: next address is 0x300.
- `imem_ready` low for 3 cycles at addr 0x120, `isBranch` to 0x500 in cycle 1 and `Jump` to 0x600 in cycle 2: `imem_addr` holds 0x120 until ready, `fetch_busy` = 1, the data is discarded, and the next address is 0x600.
- RESET_PC = 0xFFFF_FFF8, zero-wait: addresses go 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. `branch_target` 0x203 is fetched as 0x200.
- `rst_n` pulsed low while `imem_ready` = 0 in FETCH: `imem_req` drops immediately and IF/ID clears. The first request after release is to RESET_PC.
